// File: rtl/joybus_sniffer_multi.sv
// joybus_sniffer_multi: passive N64 Joybus sniffer for up to four ports with toggle handoff and in-game reset
// Define JOYBUS_IGR_HOLD_EN to require IGR_HOLD_POLLS consecutive combo polls before the reset pulse fires.
module joybus_sniffer_multi #(
  parameter int NUM_PORTS = 1,
  parameter int PRESCALE = 12,
  parameter logic [7:0] CMD_POLL = 8'h01,
  parameter logic [15:0] IGR_COMBO = 16'h3030,
  parameter int IGR_HOLD_POLLS = 30,
  parameter logic [19:0] RST_TICKS = 20'hFFFFF
) (
  input  logic N64_CLK_i,
  input  logic CTRL_nRST,
  input  logic [NUM_PORTS-1:0] CTRL_i,
  input  logic use_igr_i,
  output logic [32*NUM_PORTS-1:0] ctrl_data_o,
  output logic [NUM_PORTS-1:0] data_req_o,
  input  logic [NUM_PORTS-1:0] data_ack_i,
  output logic [NUM_PORTS-1:0] frame_err_o,
  output logic N64_nRST_oe_o
);
  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;
  localparam int DW = $clog2(PRESCALE + 1);
  localparam logic [DW-1:0] DMAX = DW'(PRESCALE - 1);
  logic [DW-1:0] div;
  logic tick, commit0, match, blocked, fire;
  logic [15:0] pend0;
  logic [19:0] rc;
  assign tick = div == DMAX;
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST)
    if (!CTRL_nRST) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t st, st_nx;
    logic [1:0] sync;
    logic [2:0] hist;
    logic [7:0] cnt, low_len;
    logic [5:0] nb, nb_nx;
    logic [31:0] sh, sh_nx, pend, data;
    logic pv, req, err, neg, pos, sat, bitv, done, bad, commit;
    assign neg = tick & hist[2] & ~hist[1];
    assign pos = tick & ~hist[2] & hist[1];
    assign sat = cnt == 8'hFF;
    assign bitv = low_len < cnt;
    assign commit = pv & (req == data_ack_i[p]);
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST)
      if (!CTRL_nRST) begin
        sync <= '0;
        hist <= 3'b111;
        cnt <= '0;
        low_len <= '0;
        st <= IDLE;
        nb <= '0;
        sh <= '0;
        pend <= '0;
        data <= '0;
        pv <= 1'b0;
        req <= 1'b0;
        err <= 1'b0;
      end else begin
        sync <= {sync[0], CTRL_i[p]};
        st <= st_nx;
        nb <= nb_nx;
        sh <= sh_nx;
        if (tick) hist <= {hist[1:0], sync[1]};
        if (tick) cnt <= (neg | pos) ? '0 : sat ? cnt : cnt + 1'b1;
        if (pos) low_len <= cnt;
        // A frame finishing alongside a commit stays pending; latest frame always wins
        if (done) begin
          pend <= sh_nx;
          pv <= 1'b1;
        end else if (commit) pv <= 1'b0;
        if (commit) begin
          data <= pend;
          req <= ~req;
        end
        err <= bad | (err & ~commit);
      end
    always_comb begin
      st_nx = st;
      nb_nx = nb;
      sh_nx = sh;
      done = 1'b0;
      bad = 1'b0;
      if (st == IDLE) begin
        nb_nx = '0;
        sh_nx = '0;
        if (neg & sat) st_nx = CMD;
      end else if (neg) begin
        nb_nx = nb + 1'b1;
        if (st == CMD) begin
          if (nb == 6'd8) begin
            st_nx = (sh[7:0] == CMD_POLL) ? RSP : IDLE;
            nb_nx = '0;
            sh_nx = '0;
          end else sh_nx = {sh[30:0], bitv};
        end else begin
          sh_nx[nb[4:0]] = bitv;
          if (nb == 6'd31) begin
            st_nx = IDLE;
            done = 1'b1;
          end
        end
      end else if (tick & sat) begin
        st_nx = IDLE;
        bad = 1'b1;
      end
    end
    assign ctrl_data_o[32*p +: 32] = data;
    assign data_req_o[p] = req;
    assign frame_err_o[p] = err;
    if (p == 0) begin : g_p0
      assign commit0 = commit;
      assign pend0 = pend[15:0];
    end
  end
  assign match = use_igr_i & (pend0 == IGR_COMBO);
`ifdef JOYBUS_IGR_HOLD_EN
  logic [5:0] hc;
  assign fire = commit0 & match & ~N64_nRST_oe_o & ~blocked & (hc == 6'(IGR_HOLD_POLLS - 1));
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST)
    if (!CTRL_nRST) hc <= '0;
    else if (commit0) hc <= (~match | fire) ? '0 : (N64_nRST_oe_o | blocked) ? hc : hc + 1'b1;
`else
  assign fire = commit0 & match & ~N64_nRST_oe_o & ~blocked & (IGR_HOLD_POLLS >= 0);
`endif
  // blocked keeps a still-held combo from re-firing until a non-matching poll is seen
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST)
    if (!CTRL_nRST) begin
      N64_nRST_oe_o <= 1'b0;
      rc <= '0;
      blocked <= 1'b0;
    end else begin
      if (fire) begin
        N64_nRST_oe_o <= 1'b1;
        rc <= RST_TICKS;
      end else if (tick & N64_nRST_oe_o) begin
        if (rc == '0) N64_nRST_oe_o <= 1'b0;
        else rc <= rc - 1'b1;
      end
      blocked <= fire | (blocked & ~(commit0 & ~match));
    end
endmodule

// File: doc/joybus_sniffer_multi.md
Name: joybus_sniffer_multi

Overview:
- Passively sniffs N64 Joybus traffic on up to four controller lines.
- Decodes console command bytes and the 32-bit controller responses to the poll command.
- Hands each port's latest response to the CPU domain via a toggle req/ack handshake.
- Issues an in-game-reset (IGR) pulse on N64_nRST when port 0 reports the configured button combo. Generalised successor of the single-port 4 MHz sniffer; runs directly on N64_CLK_i with an internal prescaler.

Parameters:
- NUM_PORTS, 1, number of sniffed controller lines (1..4).
- PRESCALE, 12, N64_CLK_i cycles per sample tick (~4 MHz at 48.7 MHz).
- CMD_POLL, 8'h01, command byte whose response is captured.
- IGR_COMBO, 16'h3030, required value of response bits [15:0] on port 0 to trigger IGR.
- IGR_HOLD_POLLS, 30, consecutive matching polls required (only with the optional feature).
- RST_TICKS, 20'hFFFFF, reset pulse length in sample ticks.

Ports:
- N64_CLK_i  in  1  system clock; all logic on rising edge.
- CTRL_nRST  in  1  asynchronous, active-low reset.
- CTRL_i  in  NUM_PORTS  raw Joybus lines, asynchronous.
- use_igr_i  in  1  IGR enable, quasi-static.
- ctrl_data_o  out  32*NUM_PORTS  committed response per port; port p at [32p+31:32p].
- data_req_o  out  NUM_PORTS  per-port toggle; flips when new data is committed.
- data_ack_i  in  NUM_PORTS  per-port toggle from consumer, already synchronised.
- frame_err_o  out  NUM_PORTS  sticky; set on an aborted frame, cleared by the next commit on that port.
- N64_nRST_oe_o  out  1  1 = drive N64 reset low.

Behaviour:
- Reset values: all outputs and registers 0; tick divider 0; sample history all 1s; FSMs in IDLE.
- Tick: divider counts 0..PRESCALE-1, with tick asserted when the divider wraps. All bit-level logic advances only on tick.
- Per-port input path: 2-flop synchroniser plus a 3-bit history shifted on tick.
  - negedge = hist[2] & !hist[1]; posedge = !hist[2] & hist[1].
- Per-port 8-bit tick counter: cleared on either edge, otherwise increments and saturates at 255.
  - At posedge: low_len <= counter.
  - At negedge: bit = (low_len < counter), i.e. low shorter than high = 1.
- FSM per port, with states IDLE, CMD, RSP:
  - IDLE: leaves to CMD on a negedge only while the counter is saturated (line idle ≥255 ticks). Clears bit count and shift register.
  - CMD: on each negedge, stores the bit MSB-first (first bit -> cmd[7]) until 8 bits are held. At the next negedge, if cmd == CMD_POLL go to RSP (clear count and shift register); otherwise go to IDLE.
  - RSP: the k-th received bit goes to shift[k] (k = 0..31). When the 32nd bit is decoded, go to IDLE and push shift to the pending register; pending_valid <= 1.
  - Counter saturation in CMD or RSP: go to IDLE and set frame_err_o[p]. Saturation in IDLE is normal idle.
- Handshake, per port:
  - Commit happens when pending_valid and data_req_o[p] == data_ack_i[p]. On commit: ctrl_data_o <= pending, data_req_o flips, pending_valid <= 0, frame_err_o <= 0.
  - A new frame completing while pending_valid is still 1 overwrites pending (latest wins, no stall).
  - If completion and commit happen in the same cycle, the new frame stays in pending and the old pending is committed.
  - Commit latency: 1 clock after the final bit is decoded when the channel is free.
- IGR, port 0 only, evaluated on each port-0 commit:
  - match = use_igr_i & (committed[15:0] == IGR_COMBO).
  - A match arms the pulse: N64_nRST_oe_o <= 1 and the tick counter loads RST_TICKS. The counter decrements per tick; N64_nRST_oe_o <= 0 when it reaches 0.
  - While the pulse is active, matches are ignored.
  - After release, a new pulse requires at least one non-matching commit first (no re-fire while the combo is still held).
  - use_igr_i = 0 blocks new triggers but does not abort an active pulse.
- Reset asserted mid-frame or mid-pulse: everything returns immediately to reset values and N64_nRST_oe_o drops.

Optional Feature:
- Macro: JOYBUS_IGR_HOLD_EN.
- Defined: a 6-bit counter increments on each matching port-0 commit and clears on any non-matching commit. The pulse arms when the counter reaches IGR_HOLD_POLLS; the counter then clears.
- Undefined: counter logic is absent and the first matching commit arms the pulse. IGR_HOLD_POLLS is unused.

Test Plan:
- Port 0 idle 300 ticks, then cmd 0x01 plus response 32'h00000001 (bit0 = 1) -> data_req_o[0] toggles once; ctrl_data_o[31:0] = 32'h00000001; frame_err_o[0] = 0.
- Cmd 0x00 followed by a 24-bit reply -> no toggle, ctrl_data_o unchanged, FSM back in IDLE.
- Line held high for 300 ticks after 10 response bits -> frame_err_o[0] = 1; next valid frame commits and clears it.
- Acks withheld, three frames A, B, C sent, then ack toggled -> first commit = A; after ack, C commits; B is never seen.
- NUM_PORTS = 4, simultaneous polls with distinct data 1/2/3/4 -> each slice holds its own value; all four req bits toggle.
- use_igr_i = 1, response[15:0] = IGR_COMBO:
  - Feature off: N64_nRST_oe_o high for RST_TICKS+1 ticks; the repeated combo does not retrigger until a non-match.
  - Feature on: 29 matching polls give no pulse; the 30th arms it.
